// File: rtl/oled_spi_sink.sv
// oled_spi_sink: receives the SPI byte stream an SSD1306-style OLED driver
// emits, decodes the column/page addressing commands and the display on/off
// commands, and turns display-data bytes into framebuffer write strobes.
// The SPI pins are oversampled in the clk domain; spi_clk high and low
// phases must each last at least two clk periods.
module oled_spi_sink #(
  parameter int NUM_COLS  = 128,
  parameter int NUM_PAGES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       mosi,
  input  logic       dc,
  input  logic       cs_n,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       display_on,
  output logic       proto_err
);

  localparam int COL_W  = 7;
  localparam int PAGE_W = 3;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

  // Synchronizer lanes: bit 0 spi_clk, bit 1 mosi, bit 2 dc, bit 3 cs_n.
  // cs_n idles deasserted (high), everything else idles low.
  localparam int NUM_SYNC = 4;
  localparam logic [NUM_SYNC-1:0] SYNC_RST = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COL_START  = 3'd1,
    ST_COL_END    = 3'd2,
    ST_PAGE_START = 3'd3,
    ST_PAGE_END   = 3'd4,
    ST_SKIP1      = 3'd5
  } state_t;

  logic [NUM_SYNC-1:0] sync_in;
  logic [NUM_SYNC-1:0] sync1_reg;
  logic [NUM_SYNC-1:0] sync2_reg;

  logic spi_clk_sync;
  logic mosi_sync;
  logic dc_sync;
  logic cs_n_sync;
  logic spi_prev_reg;

  logic spi_rise;
  logic capture;
  logic byte_done;
  logic [7:0] rx_byte;

  // Only the first seven bits need storing; the eighth is taken straight
  // from the synchronizer when the byte completes.
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt_reg;

  state_t state_reg, state_next;

  logic [COL_W-1:0]  col_reg, col_next;
  logic [COL_W-1:0]  col_start_reg, col_start_next;
  logic [COL_W-1:0]  col_end_reg, col_end_next;
  logic [PAGE_W-1:0] page_reg, page_next;
  logic [PAGE_W-1:0] page_start_reg, page_start_next;
  logic [PAGE_W-1:0] page_end_reg, page_end_next;

  logic       fb_we_reg, fb_we_next;
  logic [9:0] fb_addr_reg, fb_addr_next;
  logic [7:0] fb_wdata_reg, fb_wdata_next;
  logic       cmd_valid_reg, cmd_valid_next;
  logic [7:0] cmd_byte_reg, cmd_byte_next;
  logic       display_on_reg, display_on_next;
  logic       proto_err_reg, proto_err_next;

  assign sync_in = {cs_n, dc, mosi, spi_clk};

  generate
    for (genvar gi = 0; gi < NUM_SYNC; gi++) begin : g_sync
      // Two-flop synchronizer for one asynchronous SPI pin.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg[gi] <= SYNC_RST[gi];
          sync2_reg[gi] <= SYNC_RST[gi];
        end else begin
          sync1_reg[gi] <= sync_in[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  assign spi_clk_sync = sync2_reg[0];
  assign mosi_sync    = sync2_reg[1];
  assign dc_sync      = sync2_reg[2];
  assign cs_n_sync    = sync2_reg[3];

  // Remember the previous synchronized spi_clk level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_prev_reg <= 1'b0;
    end else begin
      spi_prev_reg <= spi_clk_sync;
    end
  end

  assign spi_rise  = spi_clk_sync & ~spi_prev_reg;
  assign capture   = spi_rise & ~cs_n_sync;
  assign byte_done = capture & (bit_cnt_reg == 3'd7);
  assign rx_byte   = {shift_reg, mosi_sync};

  // Bit assembly: shift MSB first while selected; deselect drops any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (cs_n_sync) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (capture) begin
      shift_reg   <= rx_byte[6:0];
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end
  end

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Parser next state: commands walk the argument states, a data byte always
  // returns to IDLE (flagged as an error elsewhere when it interrupts a command).
  always_comb begin
    state_next = state_reg;
    if (byte_done) begin
      if (dc_sync) begin
        state_next = ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            case (rx_byte)
              8'h21:        state_next = ST_COL_START;
              8'h22:        state_next = ST_PAGE_START;
              8'h20, 8'h81: state_next = ST_SKIP1;
              default:      state_next = ST_IDLE;
            endcase
          end
          ST_COL_START:  state_next = ST_COL_END;
          ST_COL_END:    state_next = ST_IDLE;
          ST_PAGE_START: state_next = ST_PAGE_END;
          ST_PAGE_END:   state_next = ST_IDLE;
          default:       state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Parser outputs: next values for strobes, window registers and pointers.
  always_comb begin
    fb_we_next      = 1'b0;
    fb_addr_next    = fb_addr_reg;
    fb_wdata_next   = fb_wdata_reg;
    cmd_valid_next  = 1'b0;
    cmd_byte_next   = cmd_byte_reg;
    display_on_next = display_on_reg;
    proto_err_next  = 1'b0;
    col_next        = col_reg;
    col_start_next  = col_start_reg;
    col_end_next    = col_end_reg;
    page_next       = page_reg;
    page_start_next = page_start_reg;
    page_end_next   = page_end_reg;

    if (byte_done) begin
      if (dc_sync) begin
        // Data byte: write at the current pointers even if it interrupted a command.
        fb_we_next     = 1'b1;
        fb_addr_next   = {page_reg, col_reg};
        fb_wdata_next  = rx_byte;
        proto_err_next = (state_reg != ST_IDLE);
        if (col_reg == col_end_reg) begin
          col_next = col_start_reg;
          if (page_reg == page_end_reg) begin
            page_next = page_start_reg;
          end else if (page_reg == PAGE_LAST) begin
            page_next = '0;
          end else begin
            page_next = page_reg + 3'd1;
          end
        end else if (col_reg == COL_LAST) begin
          col_next = '0;
        end else begin
          col_next = col_reg + 7'd1;
        end
      end else begin
        // Command or argument byte: always reported, then interpreted by state.
        cmd_valid_next = 1'b1;
        cmd_byte_next  = rx_byte;
        case (state_reg)
          ST_IDLE: begin
            if (rx_byte == 8'hAE) begin
              display_on_next = 1'b0;
            end else if (rx_byte == 8'hAF) begin
              display_on_next = 1'b1;
            end
          end
          ST_COL_START: col_start_next = rx_byte[COL_W-1:0];
          ST_COL_END: begin
            col_end_next = rx_byte[COL_W-1:0];
            col_next     = col_start_reg;
          end
          ST_PAGE_START: page_start_next = rx_byte[PAGE_W-1:0];
          ST_PAGE_END: begin
            page_end_next = rx_byte[PAGE_W-1:0];
            page_next     = page_start_reg;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Register outputs, addressing window and write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_wdata_reg   <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_byte_reg   <= '0;
      display_on_reg <= 1'b0;
      proto_err_reg  <= 1'b0;
      col_reg        <= '0;
      col_start_reg  <= '0;
      col_end_reg    <= COL_LAST;
      page_reg       <= '0;
      page_start_reg <= '0;
      page_end_reg   <= PAGE_LAST;
    end else begin
      fb_we_reg      <= fb_we_next;
      fb_addr_reg    <= fb_addr_next;
      fb_wdata_reg   <= fb_wdata_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_byte_reg   <= cmd_byte_next;
      display_on_reg <= display_on_next;
      proto_err_reg  <= proto_err_next;
      col_reg        <= col_next;
      col_start_reg  <= col_start_next;
      col_end_reg    <= col_end_next;
      page_reg       <= page_next;
      page_start_reg <= page_start_next;
      page_end_reg   <= page_end_next;
    end
  end

  assign fb_we      = fb_we_reg;
  assign fb_addr    = fb_addr_reg;
  assign fb_wdata   = fb_wdata_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign cmd_byte   = cmd_byte_reg;
  assign display_on = display_on_reg;
  assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Bench for oled_spi_sink: drives SPI bytes (directed and random), predicts
// writes, command strobes, protocol errors and display state with a simple
// integer model, and compares against what a monitor records from the DUT.
module tb_oled_spi_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic       dc = 1'b0;
  logic       cs_n = 1'b1;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       display_on;
  logic       proto_err;

  oled_spi_sink #(.NUM_COLS(128), .NUM_PAGES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .mosi       (mosi),
    .dc         (dc),
    .cs_n       (cs_n),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .display_on (display_on),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed and expected event streams: writes are {proto_err, addr, data}.
  logic [18:0] act_wr[$];
  logic [18:0] exp_wr[$];
  logic [7:0]  act_cmd[$];
  logic [7:0]  exp_cmd[$];
  int long_pulses  = 0;
  int orphan_perr  = 0;
  logic prev_we    = 1'b0;
  logic prev_cv    = 1'b0;
  logic prev_pe    = 1'b0;

  // Reference model state (plain integers).
  int  m_mode;  // 0 idle, 1 want col start, 2 want col end, 3 want page start, 4 want page end, 5 skip one
  int  m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  bit  m_disp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: sample outputs on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (fb_we) act_wr.push_back({proto_err, fb_addr, fb_wdata});
    if (cmd_valid) act_cmd.push_back(cmd_byte);
    if (proto_err && !fb_we) orphan_perr++;
    if ((fb_we && prev_we) || (cmd_valid && prev_cv) || (proto_err && prev_pe)) long_pulses++;
    prev_we = fb_we;
    prev_cv = cmd_valid;
    prev_pe = proto_err;
  end

  function automatic void model_reset();
    m_mode = 0; m_col = 0; m_page = 0;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_disp = 1'b0;
  endfunction

  function automatic void model_byte(input logic d, input logic [7:0] b);
    if (d) begin
      exp_wr.push_back({(m_mode != 0), 3'(m_page), 7'(m_col), b});
      m_mode = 0;
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else begin
        m_col = (m_col + 1) % 128;
      end
    end else begin
      exp_cmd.push_back(b);
      case (m_mode)
        0: begin
          if (b == 8'h21) m_mode = 1;
          else if (b == 8'h22) m_mode = 3;
          else if (b == 8'h20 || b == 8'h81) m_mode = 5;
          else if (b == 8'hAE) m_disp = 1'b0;
          else if (b == 8'hAF) m_disp = 1'b1;
        end
        1: begin m_cs = b % 128; m_mode = 2; end
        2: begin m_ce = b % 128; m_col = m_cs; m_mode = 0; end
        3: begin m_ps = b % 8; m_mode = 4; end
        4: begin m_pe = b % 8; m_page = m_ps; m_mode = 0; end
        default: m_mode = 0;
      endcase
    end
  endfunction

  // Shift the first n bits of b out MSB first, SPI mode 0, random phase length.
  task automatic send_bits(input int n, input logic d, input logic [7:0] b);
    int half;
    logic [7:0] v;
    v = b;
    dc = d;
    for (int i = 0; i < n; i++) begin
      half = $urandom_range(25, 50);
      spi_clk = 1'b0;
      mosi = v[7-i];
      #(half);
      spi_clk = 1'b1;
      #(half);
    end
    spi_clk = 1'b0;
    #(30);
  endtask

  task automatic send_byte(input logic d, input logic [7:0] b);
    cs_n = 1'b0;
    send_bits(8, d, b);
    model_byte(d, b);
    $display("tx %s 0x%02h", d ? "data" : "cmd ", b);
  endtask

  task automatic cs_toggle();
    cs_n = 1'b1;
    #(80);
    cs_n = 1'b0;
    #(80);
  endtask

  // Let outstanding strobes appear, then compare both event streams.
  task automatic drain_compare(input string tag);
    repeat (12) @(posedge clk);
    while (exp_wr.size() > 0) begin
      if (act_wr.size() == 0) begin
        chk({tag, "_wr_missing"}, 32'hFFFF_FFFF, 32'(exp_wr.pop_front()));
      end else begin
        chk({tag, "_wr"}, 32'(act_wr.pop_front()), 32'(exp_wr.pop_front()));
      end
    end
    chk({tag, "_wr_extra"}, act_wr.size(), 0);
    act_wr.delete();
    while (exp_cmd.size() > 0) begin
      if (act_cmd.size() == 0) begin
        chk({tag, "_cmd_missing"}, 32'hFFFF_FFFF, 32'(exp_cmd.pop_front()));
      end else begin
        chk({tag, "_cmd"}, 32'(act_cmd.pop_front()), 32'(exp_cmd.pop_front()));
      end
    end
    chk({tag, "_cmd_extra"}, act_cmd.size(), 0);
    act_cmd.delete();
    chk({tag, "_display_on"}, 32'(display_on), 32'(m_disp));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #(1);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_wdata", 32'(fb_wdata), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_byte", 32'(cmd_byte), 0);
    chk("rst_display_on", 32'(display_on), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] cmd_list[6] = '{8'h21, 8'h22, 8'h20, 8'h81, 8'hAE, 8'hAF};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    pulse_reset();

    // Display on/off.
    send_byte(1'b0, 8'hAF);
    drain_compare("disp_on");
    send_byte(1'b0, 8'hAE);
    drain_compare("disp_off");

    // Column window near the right edge, wrap into next page.
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h7E); send_byte(1'b0, 8'h7F);
    send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22); send_byte(1'b1, 8'h33);
    drain_compare("colwin");

    // Page window 6..7 with a single column.
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h06); send_byte(1'b0, 8'h07);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00);
    send_byte(1'b1, 8'hC1); send_byte(1'b1, 8'hC2); send_byte(1'b1, 8'hC3);
    drain_compare("pagewin");

    // Data interrupting a command argument, then an IDLE-only command.
    pulse_reset();
    send_byte(1'b0, 8'h21);
    send_byte(1'b1, 8'h55);
    send_byte(1'b0, 8'hAF);
    drain_compare("proto_err");

    // Partial byte dropped by deselect.
    cs_n = 1'b0;
    send_bits(5, 1'b1, 8'hF0);
    cs_toggle();
    send_byte(1'b1, 8'hA5);
    drain_compare("partial_cs");

    // Reset mid-command and mid-byte.
    send_byte(1'b0, 8'h21);
    send_byte(1'b0, 8'h10);
    send_bits(3, 1'b1, 8'hE0);
    drain_compare("pre_reset");
    pulse_reset();
    send_byte(1'b1, 8'h3C);
    drain_compare("post_reset");

    // Random traffic, including stray arguments and deselect gaps.
    for (int batch = 0; batch < 10; batch++) begin
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 9) < 6) begin
          send_byte(1'b1, 8'($urandom));
        end else if ($urandom_range(0, 1) == 0) begin
          send_byte(1'b0, cmd_list[$urandom_range(0, 5)]);
        end else begin
          send_byte(1'b0, 8'($urandom));
        end
        if ($urandom_range(0, 15) == 0) cs_toggle();
      end
      drain_compare("rand");
    end

    chk("long_pulses", long_pulses, 0);
    chk("orphan_proto_err", orphan_perr, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oled_spi_sink.md
OLED_SPI_SINK -- requirements
Module: oled_spi_sink

Interface
REQ-001 Parameter NUM_COLS, default 128, number of display columns; column pointers are 7 bits wide.
REQ-002 Parameter NUM_PAGES, default 8, number of 8-pixel pages; page pointers are 3 bits wide.
REQ-003 clk  input  1  system clock, the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 spi_clk  input  1  SPI clock from the OLED driver; asynchronous to clk.
REQ-006 mosi  input  1  serial data, MSB first, sampled on the spi_clk rising edge.
REQ-007 dc  input  1  0 = command byte, 1 = display-data byte.
REQ-008 cs_n  input  1  active-low chip select.
REQ-009 fb_we  output  1  one-cycle framebuffer write strobe.
REQ-010 fb_addr  output  10  write address, {page[2:0], col[6:0]}.
REQ-011 fb_wdata  output  8  write data.
REQ-012 cmd_valid  output  1  one-cycle strobe, asserted for every completed command byte, including argument bytes.
REQ-013 cmd_byte  output  8  the command byte that completed; valid while cmd_valid is high.
REQ-014 display_on  output  1  display-enable state.
REQ-015 proto_err  output  1  one-cycle strobe for a protocol violation.

Function
REQ-016 spi_clk, mosi, dc and cs_n shall each pass through a 2-flop synchronizer clocked by clk.
REQ-017 A spi_clk rising edge shall be detected by comparing the synchronized spi_clk against its previous registered value.
REQ-018 Correct capture requires spi_clk high and low phases each to be at least 2 clk periods.
REQ-019 On a detected rising edge with synchronized cs_n low: shift synchronized mosi into the shift register (MSB first) and increment a 3-bit bit counter.
REQ-020 When the 8th bit is captured: the byte is complete, dc is taken from its value sampled at that same edge, and the bit counter wraps to 0.
REQ-021 Synchronized cs_n high: clear the bit counter and discard any partial byte; no strobe is produced and parser state is retained.
REQ-022 All outputs shall be registered; a strobe for a completed byte shall be asserted on the clk cycle after the cycle in which its 8th bit is captured.
REQ-023 Parser FSM states: IDLE, COL_START, COL_END, PAGE_START, PAGE_END, SKIP1.
REQ-024 IDLE, command 0x21 -> COL_START; 0x22 -> PAGE_START; 0x20 or 0x81 -> SKIP1.
REQ-025 IDLE, command 0xAE clears display_on and 0xAF sets it; all other commands leave state unchanged and stay in IDLE.
REQ-026 COL_START: latch col_start = byte[6:0] -> COL_END.
REQ-027 COL_END: latch col_end = byte[6:0], set col = col_start -> IDLE.
REQ-028 PAGE_START: latch page_start = byte[2:0] -> PAGE_END.
REQ-029 PAGE_END: latch page_end = byte[2:0], set page = page_start -> IDLE.
REQ-030 SKIP1: discard the argument byte -> IDLE.
REQ-031 Argument bits above the pointer width shall be ignored silently.
REQ-032 Data byte (dc=1): fb_we=1, fb_addr={page,col}, fb_wdata=byte.
REQ-033 After each data byte: if col==col_end then col=col_start and page advances; otherwise col=(col+1) mod NUM_COLS.
REQ-034 Page advance: if page==page_end then page=page_start; otherwise page=(page+1) mod NUM_PAGES.
REQ-035 start > end is legal; the pointer increments modulo the width until it equals end.
REQ-036 A data byte arriving in any non-IDLE state shall pulse proto_err, force the FSM to IDLE, and still be written per REQ-032 to REQ-034 using the current pointers.
REQ-037 fb_we, cmd_valid and proto_err shall never be high for longer than one cycle per byte.

Reset
REQ-038 rst_n low shall immediately force: fb_we=0, fb_addr=0, fb_wdata=0, cmd_valid=0, cmd_byte=0, display_on=0, proto_err=0.
REQ-039 rst_n low shall also force: FSM=IDLE, bit counter=0, shift register=0, col=0, page=0, col_start=0, col_end=NUM_COLS-1, page_start=0, page_end=NUM_PAGES-1, and synchronizer flops to 1 for cs_n and 0 for the others.
REQ-040 Reset asserted mid-byte shall discard the partial byte; the first byte after release is assembled from 8 fresh bits.

Verification
REQ-041 Command 0xAF -> one cmd_valid pulse with cmd_byte=0xAF, display_on=1; then 0xAE -> display_on=0.
REQ-042 Commands 0x21,0x7E,0x7F then data 0x11,0x22,0x33 -> writes at fb_addr 0x07E, 0x07F, 0x0FE.
REQ-043 Commands 0x22,0x06,0x07; 0x21,0x00,0x00; then data x3 -> addresses 0x300, 0x380, 0x300.
REQ-044 Command 0x21 then a data byte 0x55 -> one proto_err pulse, write of 0x55 at 0x000, FSM back in IDLE.
REQ-045 cs_n raised after 5 bits, then a full data byte 0xA5 -> exactly one fb_we pulse, with fb_wdata=0xA5.
REQ-046 rst_n pulsed low after 0x21,0x10 -> the next data byte writes at 0x000 and no proto_err is produced.
